// File: rtl/imem_pipelined_pkg.sv
// imem_pipelined_pkg: shared instruction types, fault codes and fetch classification
package imem_pipelined_pkg;

   typedef logic [31:0] inst_t;
   localparam inst_t INST_NOP = 32'h0000_0013;

   typedef enum logic [1:0] {IMF_NONE, IMF_MISALIGN, IMF_RANGE} imem_fault_t;

   typedef struct packed {
      logic [31:0] pc;
      imem_fault_t fault;
   } imem_meta_t;

   typedef struct packed {
      logic [31:0] pc;
      inst_t       inst;
      imem_fault_t fault;
   } imem_resp_t;

   function automatic imem_fault_t classify(input logic [31:0] pc, input logic [31:0] off,
                                            input logic [31:0] base, input int unsigned depth);
      return (pc[1:0] != 2'b00) ? IMF_MISALIGN :
             (pc < base || (off >> 2) >= depth) ? IMF_RANGE : IMF_NONE;
   endfunction

endpackage

// File: rtl/imem_pipelined_if.sv
// imem_pipelined_if: fetch request/response bus between the PC stage and the instruction memory
interface imem_pipelined_if;
   import imem_pipelined_pkg::*;

   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_pc;
   logic        flush;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_pc;
   inst_t       resp_inst;
   imem_fault_t resp_fault;

   modport master (output req_valid, req_pc, flush, resp_ready,
                   input  req_ready, resp_valid, resp_pc, resp_inst, resp_fault);
   modport slave  (input  req_valid, req_pc, flush, resp_ready,
                   output req_ready, resp_valid, resp_pc, resp_inst, resp_fault);
endinterface

// File: rtl/imem_resp_fifo.sv
// imem_resp_fifo: synchronous first-word-fall-through FIFO with clear
module imem_resp_fifo #(
   parameter int W = 8,
   parameter int D = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_clear,
   input  logic         i_push,
   input  logic         i_pop,
   input  logic [W-1:0] i_data,
   output logic [W-1:0] o_data,
   output logic         o_full,
   output logic         o_empty
);
   localparam int AW = $clog2(D);
   localparam int CW = $clog2(D + 1);

   logic [W-1:0]  r_mem [D];
   logic [AW-1:0] r_rd, r_wr;
   logic [CW-1:0] r_cnt;

   function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
      return (p == AW'(D - 1)) ? '0 : p + AW'(1);
   endfunction

   // storage write; stale slots are harmless because clear resets the pointers
   always_ff @(posedge clk)
      if (i_push) r_mem[r_wr] <= i_data;

   // pointers and occupancy; push and pop together leave the count unchanged
   always_ff @(posedge clk)
      if (reset || i_clear) begin
         r_rd  <= '0;
         r_wr  <= '0;
         r_cnt <= '0;
      end else begin
         if (i_push) r_wr <= nxt(r_wr);
         if (i_pop) r_rd <= nxt(r_rd);
         r_cnt <= r_cnt + CW'(i_push) - CW'(i_pop);
      end

   assign o_data  = r_mem[r_rd];
   assign o_full  = r_cnt == CW'(D);
   assign o_empty = r_cnt == '0;
endmodule

// File: rtl/imem_pipelined.sv
// imem_pipelined: credit-limited pipelined instruction ROM with in-order response FIFO and flush
module imem_pipelined
   import imem_pipelined_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS  = 4096,
   parameter int unsigned READ_LATENCY = 2,
   parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
   parameter string       INIT_FILE    = "./program.hex"
) (
   input logic clk,
   input logic reset,
   imem_pipelined_if.slave bus
);
   localparam int unsigned QDEPTH = READ_LATENCY + 1;
   localparam int CW   = $clog2(QDEPTH + 1);
   localparam int AW   = $clog2(DEPTH_WORDS);
   localparam int LAST = READ_LATENCY - 1;

   (* ram_style = "block" *) logic [31:0] r_mem [DEPTH_WORDS];
   logic [CW-1:0]           r_cnt;
   logic [READ_LATENCY-1:0] r_vld;
   imem_meta_t              r_meta [READ_LATENCY];
   inst_t                   r_data [READ_LATENCY];

   logic [31:0] w_off;
   imem_fault_t w_fault;
   logic        w_acc, w_pop, w_fpush, w_fpop, w_ffull, w_fempty;
   imem_resp_t  w_stage, w_fhead, w_head;

   assign w_off         = bus.req_pc - BASE_ADDR;
   assign w_fault       = classify(bus.req_pc, w_off, BASE_ADDR, DEPTH_WORDS);
   assign bus.req_ready = (r_cnt < CW'(QDEPTH)) && !bus.flush && !reset;
   assign w_acc         = bus.req_valid && bus.req_ready;

   assign w_stage = '{pc:    r_meta[LAST].pc,
                      inst:  (r_meta[LAST].fault == IMF_NONE) ? r_data[LAST] : INST_NOP,
                      fault: r_meta[LAST].fault};
   assign w_head  = w_fempty ? w_stage : w_fhead;
   assign w_pop   = bus.resp_valid && bus.resp_ready && !bus.flush;
   assign w_fpop  = w_pop && !w_fempty;
   assign w_fpush = r_vld[LAST] && !(w_fempty && w_pop);

   assign bus.resp_valid = (!w_fempty || r_vld[LAST]) && !reset;
   assign bus.resp_pc    = bus.resp_valid ? w_head.pc : '0;
   assign bus.resp_inst  = bus.resp_valid ? w_head.inst : INST_NOP;
   assign bus.resp_fault = bus.resp_valid ? w_head.fault : IMF_NONE;

   always_ff @(posedge clk)
      if (reset || bus.flush) r_cnt <= '0;
      else r_cnt <= r_cnt + CW'(w_acc) - CW'(w_pop);

   always_ff @(posedge clk)
      if (reset || bus.flush) r_vld <= '0;
      else r_vld <= READ_LATENCY'({r_vld, w_acc});

   always_ff @(posedge clk) begin
      if (w_acc && w_fault == IMF_NONE) r_data[0] <= r_mem[w_off[AW+1:2]];
      r_meta[0] <= '{pc: bus.req_pc, fault: w_fault};
      for (int i = 1; i < READ_LATENCY; i++) begin
         r_data[i] <= r_data[i-1];
         r_meta[i] <= r_meta[i-1];
      end
   end

   always_ff @(posedge clk)
      if (!reset && !bus.flush)
         assert (!(w_fpush && w_ffull && !w_fpop)) else $error("imem_pipelined: push when full");

   imem_resp_fifo #(.W($bits(imem_resp_t)), .D(QDEPTH)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_clear (bus.flush),
      .i_push  (w_fpush),
      .i_pop   (w_fpop),
      .i_data  (w_stage),
      .o_data  (w_fhead),
      .o_full  (w_ffull),
      .o_empty (w_fempty)
   );
endmodule

// File: tb/tb_imem_pipelined.sv
// tb_imem_pipelined: four configurations driven in lockstep against a queue-based reference model
module tb_imem_pipelined;
   import imem_pipelined_pkg::*;

   localparam int N = 4;
   localparam int          RLS   [N] = '{2, 1, 4, 2};
   localparam int          DEPS  [N] = '{64, 64, 64, 32};
   localparam logic [31:0] BASES [N] = '{32'h0, 32'h0, 32'h0, 32'h1000};
   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic [1:0]  fault;
      int          avail;
   } exp_t;

   logic        clk = 1'b0, reset = 1'b1, req_valid = 1'b0, flush = 1'b0, resp_ready = 1'b0;
   logic [31:0] req_pc = '0;
   logic [N-1:0] o_rq, o_rv;
   logic [31:0]  o_pc [N];
   logic [31:0]  o_in [N];
   logic [1:0]   o_ft [N];

   exp_t mq [N][$];
   int   cyc = 0, checks = 0, failures = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] word(input longint i);
      return 32'(i * 32'h9E37_79B9 + 32'h0000_1234);
   endfunction

   imem_pipelined_if bus [N] ();

   for (genvar g = 0; g < N; g++) begin : g_dut
      assign bus[g].req_valid  = req_valid;
      assign bus[g].req_pc     = req_pc;
      assign bus[g].flush      = flush;
      assign bus[g].resp_ready = resp_ready;
      assign o_rq[g] = bus[g].req_ready;
      assign o_rv[g] = bus[g].resp_valid;
      assign o_pc[g] = bus[g].resp_pc;
      assign o_in[g] = bus[g].resp_inst;
      assign o_ft[g] = bus[g].resp_fault;
      imem_pipelined #(
         .DEPTH_WORDS  (DEPS[g]),
         .READ_LATENCY (RLS[g]),
         .BASE_ADDR    (BASES[g]),
         .INIT_FILE    ("")
      ) u_dut (
         .clk   (clk),
         .reset (reset),
         .bus   (bus[g])
      );
      initial for (int i = 0; i < DEPS[g]; i++) u_dut.r_mem[i] = word(i);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic exp_t ref_fetch(input int k, input logic [31:0] pc);
      exp_t e;
      longint off = longint'(pc) - longint'(BASES[k]);
      e.pc    = pc;
      e.avail = cyc + RLS[k];
      if (pc % 4 != 0) e.fault = 2'd1;
      else if (off < 0 || off / 4 >= DEPS[k]) e.fault = 2'd2;
      else e.fault = 2'd0;
      e.inst = (e.fault == 2'd0) ? word(off / 4) : NOP;
      return e;
   endfunction

   task automatic step(input logic v, input logic [31:0] pc, input logic rr,
                       input logic fl = 1'b0, input logic rs = 1'b0);
      req_valid = v; req_pc = pc; resp_ready = rr; flush = fl; reset = rs;
      #3;
      for (int k = 0; k < N; k++) begin
         logic erq, erv;
         erq = !reset && !flush && mq[k].size() < RLS[k] + 1;
         erv = !reset && mq[k].size() > 0 && mq[k][0].avail <= cyc;
         chk($sformatf("req_ready[%0d]@%0d", k, cyc), 32'(o_rq[k]), 32'(erq));
         chk($sformatf("resp_valid[%0d]@%0d", k, cyc), 32'(o_rv[k]), 32'(erv));
         if (erv) begin
            chk($sformatf("resp_pc[%0d]@%0d", k, cyc), o_pc[k], mq[k][0].pc);
            chk($sformatf("resp_inst[%0d]@%0d", k, cyc), o_in[k], mq[k][0].inst);
            chk($sformatf("resp_fault[%0d]@%0d", k, cyc), 32'(o_ft[k]), 32'(mq[k][0].fault));
         end
         if (reset) begin
            chk($sformatf("rst_pc[%0d]@%0d", k, cyc), o_pc[k], 32'h0);
            chk($sformatf("rst_inst[%0d]@%0d", k, cyc), o_in[k], NOP);
            chk($sformatf("rst_fault[%0d]@%0d", k, cyc), 32'(o_ft[k]), 32'h0);
         end
         if (reset || flush) mq[k].delete();
         else begin
            if (erv && resp_ready) void'(mq[k].pop_front());
            if (req_valid && erq) mq[k].push_back(ref_fetch(k, req_pc));
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic idle(input int n, input logic rr);
      for (int i = 0; i < n; i++) step(1'b0, 32'h0, rr);
   endtask

   initial begin
      @(posedge clk);
      #1;
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
      // streaming words 0..3
      for (int i = 0; i < 4; i++) step(1'b1, 32'(4 * i), 1'b1);
      idle(6, 1'b1);
      // backpressure then drain
      step(1'b1, 32'h10, 1'b1);
      for (int i = 1; i < 7; i++) step(1'b1, 32'(32'h10 + 4 * i), 1'b0);
      idle(8, 1'b1);
      // fault classification
      step(1'b1, 32'h6, 1'b1);
      step(1'b1, 32'h100, 1'b1);
      step(1'b1, 32'h0FFC, 1'b1);
      step(1'b1, 32'h1080, 1'b1);
      step(1'b1, 32'h1004, 1'b1);
      step(1'b1, 32'hFFFF_FFFC, 1'b1);
      idle(6, 1'b1);
      // flush with three outstanding and a request in the flush cycle
      step(1'b1, 32'h20, 1'b0);
      step(1'b1, 32'h24, 1'b0);
      step(1'b1, 32'h28, 1'b0);
      step(1'b1, 32'h2C, 1'b1, 1'b1);
      step(1'b1, 32'h40, 1'b1);
      idle(7, 1'b1);
      // reset with fetches in flight
      step(1'b1, 32'h0, 1'b1);
      step(1'b1, 32'h4, 1'b1);
      step(1'b1, 32'h8, 1'b1, 1'b0, 1'b1);
      idle(7, 1'b1);
      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         logic [31:0] pc;
         pc = (($urandom % 2) ? 32'h1000 : 32'h0) + 32'(($urandom % 80) * 4) - 32'h8;
         if ($urandom % 8 == 0) pc = pc + 32'($urandom % 4);
         step($urandom % 4 != 0, pc, $urandom % 3 != 0, $urandom % 25 == 0, $urandom % 70 == 0);
      end
      idle(8, 1'b1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/imem_pipelined.md
Name: imem_pipelined

Overview:
- Parametrised next-generation instruction memory for the RISC-V core.
- Replaces the fixed single-cycle fetch/stall/flush scheme with a valid/ready request and response interface.
- Read latency is configurable; an in-order response FIFO absorbs downstream backpressure, and a flush kills all in-flight fetches.
- Sits between the PC/fetch stage and the decode stage. Faults are classified per fetch rather than by a single flag.

Parameters:
- DEPTH_WORDS, 4096, number of 32-bit instruction words (≥2).
- READ_LATENCY, 2, cycles from request acceptance to earliest response (1..4).
- BASE_ADDR, 32'h0000_0000, byte address of word 0 (word aligned).
- INIT_FILE, "./program.hex", $readmemh image loaded at elaboration.
- Derived localparam QDEPTH = READ_LATENCY+1: credit limit and response FIFO depth.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous reset, active-high.
- req_valid  in  1  fetch request present.
- req_ready  out  1  request can be accepted this cycle.
- req_pc  in  32  fetch byte address.
- flush  in  1  discard all outstanding fetches (redirect/trap).
- resp_valid  out  1  response at FIFO head valid.
- resp_ready  in  1  consumer takes the head this cycle.
- resp_pc  out  32  pc of the head response.
- resp_inst  out  inst_t  fetched instruction; INST_NOP on fault.
- resp_fault  out  imem_fault_t  IMF_NONE / IMF_MISALIGN / IMF_RANGE.

Behaviour:
- Reset (synchronous, highest priority):
  - Clears all pipeline valids, FIFO pointers and the credit count.
  - resp_valid=0, resp_inst=INST_NOP, resp_fault=IMF_NONE, resp_pc=0.
  - req_ready=0 during reset, 1 from the first cycle after.
  - Reset mid-operation silently drops everything; no response ever emerges for pre-reset requests.
- Accept = req_valid && req_ready. req_ready = (count < QDEPTH) && !flush && !reset. Both are purely registered or combinational from registers plus flush and reset; there is no path from req_valid.
- Credit count:
  - +1 on accept, −1 on pop (resp_valid && resp_ready); unchanged when both occur.
  - Never exceeds QDEPTH and never underflows.
- Fault classification at accept, in priority order:
  - req_pc[1:0]!=0 → IMF_MISALIGN.
  - req_pc<BASE_ADDR or ((req_pc−BASE_ADDR)>>2) ≥ DEPTH_WORDS → IMF_RANGE.
  - Otherwise IMF_NONE.
  - A faulted entry does not read the array; it carries INST_NOP and still occupies a slot and produces a response.
- Pipeline:
  - READ_LATENCY register stages, each carrying {valid, pc, fault}.
  - Stage 1 is the registered array read: word index = (req_pc−BASE_ADDR)[31:2], 32-bit subtraction.
  - The final stage writes the FIFO at its clock edge.
  - Request accepted in cycle 0 with FIFO empty → resp_valid=1 in cycle READ_LATENCY.
  - Back-to-back accepts with resp_ready held 1 sustain 1 response per cycle.
- FIFO:
  - Depth QDEPTH, in-order, first-word-fall-through head drives resp_*.
  - Push and pop in the same cycle are legal, including when full or when it holds one entry.
  - Overflow is impossible by construction of the credit count; the assertion "push when full" must never fire.
  - resp_* hold stable while resp_valid && !resp_ready.
- Flush:
  - Invalidates all pipeline stages and empties the FIFO at that edge; count becomes 0.
  - resp_valid=0 in the next cycle.
  - A pop or request in the flush cycle is ignored; req_ready=0 in that cycle.
  - A request in the cycle after flush is accepted normally.
- Array: 32-bit words, inferred block RAM (ram_style "block"), read-only, one read per cycle. Array contents are never reset.

Decomposition:
- In riscv_defines, add typedef enum logic [1:0] imem_fault_t {IMF_NONE, IMF_MISALIGN, IMF_RANGE}.
- Reuse inst_t and INST_NOP from riscv_defines.
- Sub-module imem_resp_fifo: parametrised width/depth synchronous FWFT FIFO with push, pop, clear (flush), full and empty.

Test Plan:
- Streaming: reset, then READ_LATENCY=2, resp_ready=1, pc 0x0,0x4,0x8,0xC on consecutive cycles → responses in cycles 2..5 with program words 0..3 and IMF_NONE.
- Backpressure: resp_ready=0 after the first response, keep issuing → req_ready drops after count=3 with the FIFO holding 3 entries; raise resp_ready → remaining responses in order, no loss or duplicate.
- Faults: pc=0x6 → IMF_MISALIGN with INST_NOP. pc=BASE_ADDR+4*DEPTH_WORDS → IMF_RANGE. pc=BASE_ADDR−4 with BASE_ADDR=0x1000 → IMF_RANGE.
- Flush: 3 outstanding fetches plus req_valid in the flush cycle → that request is not accepted, resp_valid=0 the next cycle, no stale response ever appears, and pc 0x40 issued after the flush returns word 16.
- Reset mid-stream: assert reset with 2 in flight → outputs at reset values, no stale response afterwards.
- Latency sweep: READ_LATENCY=1 and READ_LATENCY=4 → first response exactly 1 or 4 cycles after accept, and 1 response/cycle throughput.
